// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the MIPS32 iterative multiply/divide unit:
// operation encodings, control FSM states and default datapath widths.
package muldiv_unit_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MULTU = 3'd0,
    MD_MULT  = 3'd1,
    MD_DIVU  = 3'd2,
    MD_DIV   = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iteration datapath shared by multiply (shift-add) and restoring
// divide. Operates on magnitudes only; sign handling lives in the caller.
module md_iter_core
  import muldiv_unit_pkg::*;
#(
  parameter int W = MD_XLEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] acc
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [W:0]     mul_sum;
  logic [W:0]     div_diff;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_diff = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
    if (load) begin
      if (is_div) begin
        acc_d  = {{W{1'b0}}, a_in};
        opnd_d = b_in;
      end else begin
        acc_d  = {{W{1'b0}}, b_in};
        opnd_d = a_in;
      end
    end else if (step) begin
      if (!is_div) begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end else if (!div_diff[W]) begin
        // No borrow: keep the difference and shift in a quotient 1.
        acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS32 multiply/divide unit with architectural HI/LO. MULT/DIV run 32
// iterations plus one sign-fix cycle; MTHI/MTLO complete in a single cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output md_state_e       dbg_state
);

  // Handshake: start/op/A/B are sampled on a rising edge only while busy is
  // low; requests while busy are dropped. done is a one-cycle pulse in the
  // cycle after HI/LO were written by MULT/DIV (never by MTHI/MTLO).

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  logic             sgn_a, sgn_b;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             core_load, core_step, core_is_div;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]  quo, rem;

  // op[0] marks the signed variants of both MULT and DIV.
  assign sgn_a = op[0] & A[XLEN-1];
  assign sgn_b = op[0] & B[XLEN-1];
  assign a_mag = sgn_a ? -A : A;
  assign b_mag = sgn_b ? -B : B;

  assign core_is_div = core_load ? op[1] : is_div_q;

  md_iter_core #(.W(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst),
    .load   (core_load),
    .step   (core_step),
    .is_div (core_is_div),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .acc    (acc)
  );

  assign prod = neg_res_q ? -acc : acc;
  assign quo  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: begin
              core_load = 1'b1;
              is_div_d  = op[1];
              neg_res_d = sgn_a ^ sgn_b;
              neg_rem_d = sgn_a;
              div0_d    = (B == '0);
              cnt_d     = '0;
              state_d   = CALC;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      CALC: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == {CNT_W{1'b1}}) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (div0_q) begin
          // Divisor zero leaves |A| as remainder; re-signing it restores A exactly.
          hi_d = rem;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit with an expected-result queue
// filled at issue time and drained when done pulses.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;
  md_state_e   dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .HI        (HI),
    .LO        (LO),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    case (o)
      3'd0: return {32'b0, a} * {32'b0, b};
      3'd1: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  // Waits (bounded) for done, checking latency, busy, HI/LO hold and result.
  task automatic wait_done(input string tag, input int lat0);
    int          lat;
    bit          busy_ok;
    bit          hold_ok;
    logic [63:0] exp;
    lat     = lat0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ({HI, LO} !== {m_hi, m_lo}) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd33);
    check({tag, ".busy_during"}, {63'b0, busy_ok}, 64'd1);
    check({tag, ".hilo_hold"}, {63'b0, hold_ok}, 64'd1);
    check({tag, ".busy_at_done"}, {63'b0, busy}, 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, ".hilo"}, {HI, LO}, exp);
    {m_hi, m_lo} = exp;
  endtask

  task automatic check_done_low(input string tag);
    @(negedge clk);
    check({tag, ".done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    exp_q.push_back(exp);
    drive_start(o, a, b);
    wait_done(tag, 0);
    check_done_low(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    rst   = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", {63'b0, busy}, 64'd0);
    check("rst.done", {63'b0, done}, 64'd0);
    check("rst.hilo", {HI, LO}, 64'd0);
    check("rst.state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd5,         {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_op("divu_zero", MD_DIVU,  32'd100,       32'd0,         {32'h0000_0064, 32'hFFFF_FFFF});
    run_op("div_zero",  MD_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF});

    // Single-cycle moves
    drive_start(MD_MTHI, 32'h0000_CAFE, 32'd0);
    check("mthi.hi", {32'b0, HI}, {32'b0, 32'h0000_CAFE});
    check("mthi.lo", {32'b0, LO}, {32'b0, m_lo});
    check("mthi.busy_done", {62'b0, busy, done}, 64'd0);
    m_hi = 32'h0000_CAFE;
    drive_start(MD_MTLO, 32'h0000_BEEF, 32'd0);
    check("mtlo.hilo", {HI, LO}, {m_hi, 32'h0000_BEEF});
    check("mtlo.busy_done", {62'b0, busy, done}, 64'd0);
    m_lo = 32'h0000_BEEF;

    // Reserved op: no state change
    drive_start(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("rsvd.hilo", {HI, LO}, {m_hi, m_lo});
    check("rsvd.busy", {63'b0, busy}, 64'd0);

    // Requests while busy are dropped; MTLO on the done cycle is accepted
    exp_q.push_back(ref_md(MD_MULTU, 32'h1234_5678, 32'h0000_0009));
    drive_start(MD_MULTU, 32'h1234_5678, 32'h0000_0009);
    repeat (4) @(negedge clk);
    drive_start(MD_MTHI, 32'h0000_1234, 32'd0);
    repeat (4) @(negedge clk);
    drive_start(MD_DIVU, 32'd50, 32'd3);
    wait_done("busy_ignore", 10);
    drive_start(MD_MTLO, 32'h0000_0055, 32'd0);
    check("mtlo_at_done.hilo", {HI, LO}, {m_hi, 32'h0000_0055});
    check("mtlo_at_done.busy_done", {62'b0, busy, done}, 64'd0);
    m_lo = 32'h0000_0055;
    @(negedge clk);
    check("mtlo_at_done.still_idle", {63'b0, busy}, 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 15)) : $urandom);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ref_md(ro, ra, rb));
    end

    // Asynchronous reset in the middle of a DIV
    drive_start(MD_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.busy_done", {62'b0, busy, done}, 64'd0);
    check("midrst.hilo", {HI, LO}, 64'd0);
    check("midrst.state", 64'(dbg_state), 64'(IDLE));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst_multu", MD_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
